sram_line_scheduler: RTL

Schedules every access to the shared pixel SRAM between two requesters: the SPI write path, which fills the line FIFO and signals each completed line, and the HDMI scan-out path, which requests whole display lines. It tracks the drawing window set by the SPI column/row address commands and issues one burst command per line to the SRAM controller. Reads always have priority. It sits between the framebuffer FIFO writer, the HDMI timing generator and the SRAM controller.

---
 rtl/sram_line_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_line_scheduler.sv
// Arbitrates the shared pixel SRAM between SPI line writes and HDMI line reads,
// issuing one burst command per line; reads win over pending writes.
module sram_line_scheduler #(
  parameter int H_RES  = 480,
  parameter int V_RES  = 320,
  parameter int ADDR_W = 21
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_win_set,
  input  logic [15:0]       i_start_x,
  input  logic [15:0]       i_end_x,
  input  logic [15:0]       i_start_y,
  input  logic [15:0]       i_end_y,
  input  logic              i_line_write_done,
  input  logic              i_rd_req,
  input  logic [10:0]       i_rd_line,
  output logic              o_rd_ack,
  output logic              o_cmd_valid,
  output logic              o_cmd_write,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [10:0]       o_cmd_len,
  input  logic              i_cmd_ready,
  input  logic              i_cmd_done,
  output logic              o_busy,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // The whole frame must be addressable with ADDR_W bits.
  if (ADDR_W < $clog2(H_RES * V_RES)) begin : g_addr_check
    $error("ADDR_W too small for H_RES*V_RES frame");
  end

  state_t state_r;
  state_t state_nxt_s;

  logic              win_set_d_r;
  logic              win_pend_r;
  logic [10:0]       start_x_r;
  logic [10:0]       end_x_r;
  logic [10:0]       start_y_r;
  logic [10:0]       end_y_r;
  logic [10:0]       y_cur_r;
  logic [1:0]        wcnt_r;
  logic              rd_pend_r;
  logic [10:0]       rd_line_r;
  logic              cmd_valid_r;
  logic              cmd_write_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [10:0]       cmd_len_r;
  logic              rd_ack_r;
  logic              busy_r;
  logic              overflow_r;

  logic              win_edge_s;
  logic              apply_s;
  logic              issue_rd_s;
  logic              issue_wr_s;
  logic              accept_s;
  logic              rd_done_s;
  logic              wr_done_s;
  logic [10:0]       line_len_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              unused_hi_s;

  assign unused_hi_s = ^{i_start_x[15:11], i_end_x[15:11], i_start_y[15:11], i_end_y[15:11]};

  assign win_edge_s = i_win_set & ~win_set_d_r;
  // end_x < start_x wraps modulo 2^11 by design.
  assign line_len_s = end_x_r - start_x_r + 11'd1;
  assign wr_addr_s  = ADDR_W'(y_cur_r) * ADDR_W'(H_RES) + ADDR_W'(start_x_r);
  assign rd_addr_s  = ADDR_W'(rd_line_r) * ADDR_W'(H_RES);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration and burst sequencing; a pending window is applied before any burst.
  always_comb begin
    state_nxt_s = state_r;
    apply_s     = 1'b0;
    issue_rd_s  = 1'b0;
    issue_wr_s  = 1'b0;
    accept_s    = 1'b0;
    rd_done_s   = 1'b0;
    wr_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_pend_r) begin
          apply_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (rd_pend_r) begin
          issue_rd_s  = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else if (wcnt_r != 2'd0) begin
          issue_wr_s  = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_cmd_done) begin
          rd_done_s   = ~cmd_write_r;
          wr_done_s   = cmd_write_r;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Window, pending-request bookkeeping and registered command outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_set_d_r <= 1'b0;
      win_pend_r  <= 1'b0;
      start_x_r   <= 11'd0;
      end_x_r     <= 11'd0;
      start_y_r   <= 11'd0;
      end_y_r     <= 11'd0;
      y_cur_r     <= 11'd0;
      wcnt_r      <= 2'd0;
      overflow_r  <= 1'b0;
      rd_pend_r   <= 1'b0;
      rd_line_r   <= 11'd0;
      cmd_valid_r <= 1'b0;
      cmd_write_r <= 1'b0;
      cmd_addr_r  <= {ADDR_W{1'b0}};
      cmd_len_r   <= 11'd0;
      rd_ack_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      win_set_d_r <= i_win_set;
      win_pend_r  <= win_edge_s | (win_pend_r & ~apply_s);

      if (apply_s) begin
        start_x_r <= i_start_x[10:0];
        end_x_r   <= i_end_x[10:0];
        start_y_r <= i_start_y[10:0];
        end_y_r   <= i_end_y[10:0];
        y_cur_r   <= i_start_y[10:0];
      end else if (wr_done_s) begin
        y_cur_r <= (y_cur_r == end_y_r) ? start_y_r : (y_cur_r + 11'd1);
      end

      if (apply_s) begin
        wcnt_r     <= 2'd0;
        overflow_r <= 1'b0;
      end else begin
        case ({i_line_write_done, wr_done_s})
          2'b10: begin
            if (wcnt_r == 2'd3) begin
              overflow_r <= 1'b1;
            end else begin
              wcnt_r <= wcnt_r + 2'd1;
            end
          end
          2'b01:   wcnt_r <= wcnt_r - 2'd1;
          default: wcnt_r <= wcnt_r;
        endcase
      end

      // A request arriving with the completing done stays pending (latest wins).
      if (i_rd_req) begin
        rd_pend_r <= 1'b1;
        rd_line_r <= i_rd_line;
      end else if (rd_done_s) begin
        rd_pend_r <= 1'b0;
      end

      if (issue_rd_s) begin
        cmd_valid_r <= 1'b1;
        cmd_write_r <= 1'b0;
        cmd_addr_r  <= rd_addr_s;
        cmd_len_r   <= 11'(H_RES);
      end else if (issue_wr_s) begin
        cmd_valid_r <= 1'b1;
        cmd_write_r <= 1'b1;
        cmd_addr_r  <= wr_addr_s;
        cmd_len_r   <= line_len_s;
      end else if (accept_s) begin
        cmd_valid_r <= 1'b0;
      end

      rd_ack_r <= rd_done_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign o_rd_ack    = rd_ack_r;
  assign o_cmd_valid = cmd_valid_r;
  assign o_cmd_write = cmd_write_r;
  assign o_cmd_addr  = cmd_addr_r;
  assign o_cmd_len   = cmd_len_r;
  assign o_busy      = busy_r;
  assign o_overflow  = overflow_r;

endmodule
